// File: rtl/present_core_mm_block_reader.sv
`default_nettype none
// ============================================================================
// Module      : present_core_mm_block_reader
// Description : Reads blk_count 64-bit blocks from a 32-bit memory-mapped
//               port starting at word address src_addr. Each block is two
//               consecutive words: the lower address supplies out_data[63:32]
//               and the next address supplies out_data[31:0]. Blocks are
//               presented on a valid/ready stream one at a time.
//               The memory returns read data exactly one cycle after the
//               address, so the address for the high word is issued in the
//               same cycle that the low word is captured.
// Ports       : clk, reset (sync, active-high)
//               start / src_addr / blk_count  - command request
//               busy / done                   - command status
//               avm_*                         - read-only memory port
//               out_data / out_valid / out_ready - block output stream
// Config      : define PRESENT_CORE_MM_READER_BSWAP_EN to byte-reverse each
//               captured 32-bit word before it is stored.
// Revision    : 1.0 - initial release
// ============================================================================
module present_core_mm_block_reader #(
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [CNT_W-1:0]  blk_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    output logic              avm_clken,
    input  logic [31:0]       avm_readdata,
    output logic [63:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE_LO = 3'd1,
        S_CAP_LO   = 3'd2,
        S_CAP_HI   = 3'd3,
        S_OUT      = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_addr_two = ADDR_W'(2);
    localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]    r_remaining;
    logic                r_busy;
    logic                r_done;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_cs;
    logic [63:0]         r_data;
    logic                r_valid;

    // Word formatting applied to every captured read word.
    function automatic logic [31:0] f_format(input logic [31:0] w);
`ifdef PRESENT_CORE_MM_READER_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // The memory address and select are registered and loaded on the edge
    // that enters each state, so they are valid for the whole state cycle.
    // Address arithmetic wraps naturally at ADDR_W bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_addr      <= '0;
            r_cs        <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ptr       <= src_addr;
                        r_remaining <= blk_count;
                        r_addr      <= src_addr;
                        r_busy      <= 1'b1;
                        if (blk_count == '0) begin
                            // Empty command: complete without touching memory.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_cs    <= 1'b0;
                        end else begin
                            r_state <= S_ISSUE_LO;
                            r_cs    <= 1'b1;
                        end
                    end
                end
                S_ISSUE_LO: begin
                    // Low word address is on the bus now; queue the high word.
                    r_state <= S_CAP_LO;
                    r_addr  <= r_ptr + c_addr_one;
                    r_cs    <= 1'b1;
                end
                S_CAP_LO: begin
                    r_data[63:32] <= f_format(avm_readdata);
                    r_state       <= S_CAP_HI;
                    r_addr        <= r_ptr;
                    r_cs          <= 1'b0;
                end
                S_CAP_HI: begin
                    r_data[31:0] <= f_format(avm_readdata);
                    r_valid      <= 1'b1;
                    r_state      <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_valid     <= 1'b0;
                        r_ptr       <= r_ptr + c_addr_two;
                        r_addr      <= r_ptr + c_addr_two;
                        r_remaining <= r_remaining - c_cnt_one;
                        if (r_remaining > c_cnt_one) begin
                            r_state <= S_ISSUE_LO;
                            r_cs    <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cs    <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign avm_address    = r_addr;
    assign avm_chipselect = r_cs;
    assign avm_write      = 1'b0;
    assign avm_byteenable = 4'hF;
    assign avm_writedata  = 32'h0;
    assign avm_clken      = 1'b1;
    assign out_data       = r_data;
    assign out_valid      = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_present_core_mm_block_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_present_core_mm_block_reader
// Description : Directed self-checking bench for present_core_mm_block_reader
//               with a one-cycle-latency memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_present_core_mm_block_reader;

    localparam int ADDR_W = 15;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [CNT_W-1:0]  blk_count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_writedata;
    logic              avm_clken;
    logic [31:0]       avm_readdata;
    logic [63:0]       out_data;
    logic              out_valid;
    logic              out_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] reads[$];
    int                busy_cnt = 0;
    int                done_cnt = 0;
    logic [63:0]       got[$];

    present_core_mm_block_reader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .src_addr       (src_addr),
        .blk_count      (blk_count),
        .busy           (busy),
        .done           (done),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write      (avm_write),
        .avm_byteenable (avm_byteenable),
        .avm_writedata  (avm_writedata),
        .avm_clken      (avm_clken),
        .avm_readdata   (avm_readdata),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    // Memory: data for the address presented in one cycle appears in the next.
    always @(posedge clk) begin
        if (avm_chipselect) avm_readdata <= mem[avm_address];
    end

    // Per-cycle observation of the values that held during the ending cycle.
    always @(posedge clk) begin
        if (avm_chipselect) reads.push_back(avm_address);
        if (busy) busy_cnt++;
        if (done) done_cnt++;
    end

    function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef PRESENT_CORE_MM_READER_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [63:0] exp_block(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] a1;
        a1 = a + ADDR_W'(1);
        return {exp_word(mem[a]), exp_word(mem[a1])};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        reads.delete();
        got.delete();
        busy_cnt = 0;
        done_cnt = 0;
    endtask

    // Issue a command and run until done (bounded), recording handshaken blocks.
    task automatic run_cmd(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] n,
                           input int budget, output bit timed_out);
        src_addr  = a;
        blk_count = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (out_valid && out_ready) got.push_back(out_data);
            tick();
        end
        tick();
    endtask

    bit          to;
    logic [63:0] held;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hC0DE_0000 | i;
        mem[15'h0010] = 32'h0123_4567;
        mem[15'h0011] = 32'h89AB_CDEF;
        mem[15'h7FFF] = 32'hFEED_FACE;
        mem[15'h0000] = 32'h1357_9BDF;
        avm_readdata = 32'h0;
        reset = 1'b1; start = 1'b0; src_addr = '0; blk_count = '0; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // Reset state and constant outputs
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_cs", avm_chipselect, 0);
        check("rst_addr", avm_address, 0);
        check("const_wr", avm_write, 0);
        check("const_be", avm_byteenable, 4'hF);
        check("const_wd", avm_writedata, 0);
        check("const_clken", avm_clken, 1);

        // Single block, cycle by cycle
        clear_obs();
        src_addr = 15'h0010; blk_count = 1; start = 1'b1;
        tick(); start = 1'b0;
        check("b1_issue_cs", avm_chipselect, 1);
        check("b1_issue_addr", avm_address, 15'h0010);
        check("b1_issue_busy", busy, 1);
        tick();
        check("b1_caplo_cs", avm_chipselect, 1);
        check("b1_caplo_addr", avm_address, 15'h0011);
        tick();
        check("b1_caphi_cs", avm_chipselect, 0);
        check("b1_caphi_valid", out_valid, 0);
        tick();
        check("b1_out_valid", out_valid, 1);
`ifdef PRESENT_CORE_MM_READER_BSWAP_EN
        check("b1_out_data", out_data, 64'h6745_2301_EFCD_AB89);
`else
        check("b1_out_data", out_data, 64'h0123_4567_89AB_CDEF);
`endif
        tick();
        check("b1_done", done, 1);
        check("b1_valid_clr", out_valid, 0);
        tick();
        check("b1_done_clr", done, 0);
        check("b1_idle_busy", busy, 0);
        check("b1_busy_cycles", busy_cnt, 5);
        check("b1_done_cnt", done_cnt, 1);
        check("b1_nreads", reads.size(), 2);

        // Three blocks back to back
        for (int i = 0; i < 6; i++) mem[15'h20 + i] = 32'h1111_0000 * (i + 1) + i;
        clear_obs();
        run_cmd(15'h0020, 3, 60, to);
        check("b3_timeout", to, 0);
        check("b3_nreads", reads.size(), 6);
        for (int i = 0; i < 6 && i < reads.size(); i++)
            check($sformatf("b3_read%0d", i), reads[i], 15'h20 + i);
        check("b3_handshakes", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            check($sformatf("b3_blk%0d", i), got[i], exp_block(15'h20 + 2 * i));
        check("b3_done_cnt", done_cnt, 1);
        check("b3_busy_cycles", busy_cnt, 13);

        // Back-pressure in OUT
        clear_obs();
        out_ready = 1'b0;
        src_addr = 15'h0030; blk_count = 2; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        check("bp_valid", out_valid, 1);
        held = out_data;
        reads.delete();
        for (int i = 0; i < 10; i++) tick();
        check("bp_no_cs", reads.size(), 0);
        check("bp_valid_held", out_valid, 1);
        check("bp_data_held", out_data, held);
        check("bp_data", out_data, exp_block(15'h0030));
        out_ready = 1'b1;
        tick();
        check("bp_valid_clr", out_valid, 0);
        check("bp_next_cs", avm_chipselect, 1);
        check("bp_next_addr", avm_address, 15'h0032);
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (done) begin to = 1'b0; break; end
            tick();
        end
        tick();
        check("bp_timeout", to, 0);
        check("bp_done_cnt", done_cnt, 1);

        // Address wrap at the top word
        clear_obs();
        run_cmd(15'h7FFF, 1, 30, to);
        check("wr_timeout", to, 0);
        check("wr_nreads", reads.size(), 2);
        if (reads.size() == 2) begin
            check("wr_read0", reads[0], 15'h7FFF);
            check("wr_read1", reads[1], 15'h0000);
        end
`ifdef PRESENT_CORE_MM_READER_BSWAP_EN
        check("wr_data", got.size() > 0 ? got[0] : 64'hx, 64'hCEFA_EDFE_DF9B_5713);
`else
        check("wr_data", got.size() > 0 ? got[0] : 64'hx, 64'hFEED_FACE_1357_9BDF);
`endif

        // Zero-length command; start during DONE is ignored
        clear_obs();
        src_addr = 15'h0040; blk_count = 0; start = 1'b1;
        tick();
        check("z_done", done, 1);
        check("z_busy", busy, 1);
        check("z_cs", avm_chipselect, 0);
        blk_count = 1;
        tick(); start = 1'b0;
        check("z_done_clr", done, 0);
        check("z_idle_busy", busy, 0);
        tick();
        check("z_ignored_busy", busy, 0);
        check("z_no_reads", reads.size(), 0);
        check("z_done_cnt", done_cnt, 1);

        // Reset in CAP_HI aborts without done
        clear_obs();
        src_addr = 15'h0010; blk_count = 1; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        check("ab_in_caphi_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_valid", out_valid, 0);
        check("ab_data", out_data, 0);
        check("ab_cs", avm_chipselect, 0);
        tick(); tick(); tick();
        check("ab_no_done", done_cnt, 0);
        check("ab_still_idle", busy, 0);
        check("ab_valid_idle", out_valid, 0);

        // Recovery after abort
        clear_obs();
        run_cmd(15'h0010, 1, 30, to);
        check("rc_timeout", to, 0);
        check("rc_data", got.size() > 0 ? got[0] : 64'hx, exp_block(15'h0010));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
